irq_timer_ctrl: RTL

- Memory-mapped timer and interrupt controller on the data-memory bus of the single-cycle MIPS core.
- Decodes word accesses in a 32-byte window at BASE and holds the timer registers (TH/TL/TCON) plus external IRQ pending/mask registers.
- Drives the core's level interrupt input and sequences entry into and exit from the handler through an ack/done handshake, so the core is never re-interrupted while in service.

---
 rtl/irq_timer_pkg.sv | 25 ++
 rtl/irq_prio_enc.sv | 28 ++
 rtl/irq_timer_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/irq_timer_pkg.sv
// Shared definitions for the memory-mapped timer / interrupt controller:
// register offsets (word index = byte address bits 4:2), TCON bit positions,
// interrupt FSM state encoding and the "no source" SRC code.
package irq_timer_pkg;

   localparam logic [2:0] OFF_TH   = 3'd0;
   localparam logic [2:0] OFF_TL   = 3'd1;
   localparam logic [2:0] OFF_TCON = 3'd2;
   localparam logic [2:0] OFF_PEND = 3'd3;
   localparam logic [2:0] OFF_MASK = 3'd4;
   localparam logic [2:0] OFF_SRC  = 3'd5;

   localparam int TCON_EN = 0;   // count enable
   localparam int TCON_IE = 1;   // timer interrupt enable
   localparam int TCON_TF = 2;   // timer overflow status

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irqState_e;

   localparam logic [31:0] SRC_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/irq_prio_enc.sv
// Masked priority encoder for the external IRQ lines.
// Ports:
//   iReq   - masked pending vector (PEND & MASK)
//   oSrc   - lowest active index k reported as k+1, SRC_NONE when idle
//   oValid - at least one request active
module irq_prio_enc
   import irq_timer_pkg::*;
#(
   parameter int NUM_EXT = 4
) (
   input  logic [NUM_EXT-1:0] iReq,
   output logic [31:0]        oSrc,
   output logic               oValid
);

   // Scan from the top down so the lowest set index is the last to assign.
   always_comb begin
      oSrc   = SRC_NONE;
      oValid = 1'b0;
      for (int k = NUM_EXT - 1; k >= 0; k--) begin
         if (iReq[k]) begin
            oSrc   = 32'(k + 1);
            oValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_timer_ctrl.sv
// Timer and interrupt controller on the MIPS data-memory bus.
// Decodes a 32-byte register window at BASE (TH, TL, TCON, PEND, MASK, SRC),
// runs a reloading 32-bit up-counter, latches rising edges on the external
// IRQ lines, and drives a level interrupt to the core through an
// IDLE -> REQ -> SERVICE handshake so the core is never re-interrupted while
// its handler runs.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   iAddr/iMemRead/iMemWrite/iWriteData - core data bus
//   oReadData, oSel       - combinational load data and window hit
//   iExtIrq               - external requests (rising-edge sensitive)
//   iIntAck, iIntDone     - core vector-taken / handler-return pulses
//   oInterrupt            - level request to the core
module irq_timer_ctrl
   import irq_timer_pkg::*;
#(
   parameter logic [31:0] BASE    = 32'h4000_0000,
   parameter int          NUM_EXT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        iAddr,
   input  logic               iMemRead,
   input  logic               iMemWrite,
   input  logic [31:0]        iWriteData,
   output logic [31:0]        oReadData,
   output logic               oSel,
   input  logic [NUM_EXT-1:0] iExtIrq,
   input  logic               iIntAck,
   input  logic               iIntDone,
   output logic               oInterrupt
);

   logic [31:0]        th, tl;
   logic [2:0]         tcon;
   logic [NUM_EXT-1:0] pend, mask, extPrev;
   irqState_e          state, stateNext;

   logic [2:0]  off;
   logic        wrEn, ovf, anyIrq, extValid;
   logic [31:0] extSrc, src;

   // Loads have no side effects and the byte-lane bits are never decoded.
   logic unusedBits;
   assign unusedBits = ^{iMemRead, iAddr[1:0]};

   assign off   = iAddr[4:2];
   assign oSel  = (iAddr[31:5] == BASE[31:5]);
   assign wrEn  = iMemWrite & oSel;
   assign ovf   = tcon[TCON_EN] & (tl == 32'hFFFF_FFFF);

   irq_prio_enc #(.NUM_EXT(NUM_EXT)) uPrioEnc (
      .iReq   (pend & mask),
      .oSrc   (extSrc),
      .oValid (extValid)
   );

   // Timer status has priority over every external line.
   assign src    = tcon[TCON_TF] ? 32'd0 : extSrc;
   assign anyIrq = tcon[TCON_TF] | extValid;

   always_comb begin
      oReadData = 32'd0;
      if (oSel) begin
         case (off)
            OFF_TH:   oReadData = th;
            OFF_TL:   oReadData = tl;
            OFF_TCON: oReadData = {29'd0, tcon};
            OFF_PEND: oReadData = 32'(pend);
            OFF_MASK: oReadData = 32'(mask);
            OFF_SRC:  oReadData = src;
            default:  oReadData = 32'd0;
         endcase
      end
   end

   // Registers and timer. A CPU store to TL overrides count and reload;
   // a hardware overflow set of TF overrides a store clearing it, while the
   // store's enable bits still land.
   always_ff @(posedge clk) begin
      if (reset) begin
         th      <= '0;
         tl      <= '0;
         tcon    <= '0;
         pend    <= '0;
         mask    <= '0;
         extPrev <= '0;
      end else begin
         extPrev <= iExtIrq;

         if (wrEn && off == OFF_TH) th <= iWriteData;

         if (wrEn && off == OFF_TL)  tl <= iWriteData;
         else if (ovf)               tl <= th;
         else if (tcon[TCON_EN])     tl <= tl + 32'd1;

         if (wrEn && off == OFF_TCON) begin
            tcon <= iWriteData[2:0];
            if (ovf && tcon[TCON_IE]) tcon[TCON_TF] <= 1'b1;
         end else if (ovf && tcon[TCON_IE]) begin
            tcon[TCON_TF] <= 1'b1;
         end

         // W1C first, then new edges OR in so a same-cycle edge survives.
         if (wrEn && off == OFF_PEND)
            pend <= (pend & ~iWriteData[NUM_EXT-1:0]) | (iExtIrq & ~extPrev);
         else
            pend <= pend | (iExtIrq & ~extPrev);

         if (wrEn && off == OFF_MASK) mask <= iWriteData[NUM_EXT-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      oInterrupt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (anyIrq) stateNext = ST_REQ;
         end
         ST_REQ: begin
            oInterrupt = 1'b1;
            if (iIntAck)      stateNext = ST_SERVICE;
            else if (!anyIrq) stateNext = ST_IDLE;   // software withdrew it
         end
         ST_SERVICE: begin
            if (iIntDone) stateNext = anyIrq ? ST_REQ : ST_IDLE;
         end
         default: stateNext = ST_IDLE;
      endcase
   end

endmodule
